// File: rtl/ar_txd_if.sv
// ar_txd_if: host/line bundle for the ARINC 429 word transmitter.
// The master side (host) issues start with label, data and rate.
// The slave side (ar_txd) drives the line pair and the status flags.
interface ar_txd_if;
    logic        start;
    logic [7:0]  tx_adr;
    logic [22:0] tx_dat;
    logic [1:0]  speed;
    logic        out1;
    logic        out0;
    logic        busy;
    logic        done;

    modport master (
        output start, tx_adr, tx_dat, speed,
        input  out1, out0, busy, done
    );

    modport slave (
        input  start, tx_adr, tx_dat, speed,
        output out1, out0, busy, done
    );
endinterface

// File: rtl/ar_txd.sv
// ar_txd: ARINC 429 word transmitter.
// On an accepted start it latches label, data and slot length. It sends
// 32 return-to-zero bits on out1/out0: label MSB first, then data LSB
// first, then odd parity. It holds the line null for the inter-word gap,
// then pulses done.
// Optional build macro AR_TXD_PARITY_INJ_EN adds a par_inj input. When
// par_inj is set at accept, the parity bit of that word is inverted.
module ar_txd #(
    parameter int Fclk     = 50000000,
    parameter int V100kb   = 100000,
    parameter int V50kb    = 50000,
    parameter int V12_5kb  = 12500,
    parameter int GAP_BITS = 4
) (
    input  logic    clk,
    input  logic    rst,
`ifdef AR_TXD_PARITY_INJ_EN
    input  logic    par_inj,
`endif
    ar_txd_if.slave bus
);

    // Slot lengths in clocks for each rate.
    localparam int m100kb   = Fclk / V100kb;
    localparam int m50kb    = Fclk / V50kb;
    localparam int m12_5kb  = Fclk / V12_5kb;
    localparam int CW       = $clog2(m12_5kb) + 1;
    // The gap is counted in slots, so the slot counter never exceeds M-1.
    localparam int GAPSLOTS = 2 * GAP_BITS;
    localparam int GW       = (GAPSLOTS > 1) ? $clog2(GAPSLOTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   slot_q,    slot_d;
    logic [CW-1:0]   m_q,       m_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_q,     gap_d;
    logic [31:0]     sr_q,      sr_d;
    logic            out1_q,    out1_d;
    logic            out0_q,    out0_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    logic [31:0]     word_in;
    logic            par_flip;
    logic [CW-1:0]   m_sel;
    logic            slot_last;

    // Assemble the word in transmit order; sr[31] goes out first.
    always_comb begin
        par_flip = 1'b0;
`ifdef AR_TXD_PARITY_INJ_EN
        par_flip = par_inj;
`endif
        word_in[31:24] = bus.tx_adr;
        for (int k = 0; k < 23; k++) begin
            word_in[23-k] = bus.tx_dat[k];
        end
        word_in[0] = ~^{bus.tx_adr, bus.tx_dat} ^ par_flip;
    end

    // Map the requested rate to a slot length; zero marks an illegal rate.
    always_comb begin
        case (bus.speed)
            2'd1:    m_sel = CW'(m12_5kb);
            2'd2:    m_sel = CW'(m50kb);
            2'd3:    m_sel = CW'(m100kb);
            default: m_sel = '0;
        endcase
    end

    assign slot_last = (slot_q == m_q - CW'(1));

    // Next-state and next-output logic for the transmit sequencer.
    always_comb begin
        // NOTE: every _d gets a hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        slot_d    = slot_q;
        m_d       = m_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        sr_d      = sr_q;
        out1_d    = out1_q;
        out0_d    = out0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                slot_d    = '0;
                bit_cnt_d = '0;
                gap_d     = '0;
                out1_d    = 1'b0;
                out0_d    = 1'b0;
                busy_d    = 1'b0;
                if (bus.start && (bus.speed != 2'd0)) begin
                    state_d = S_HIGH;
                    m_d     = m_sel;
                    sr_d    = word_in;
                    out1_d  = word_in[31];
                    out0_d  = ~word_in[31];
                    busy_d  = 1'b1;
                end
            end

            S_HIGH: begin
                if (slot_last) begin
                    state_d   = S_LOW;
                    slot_d    = '0;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    sr_d      = {sr_q[30:0], 1'b0};
                    out1_d    = 1'b0;
                    out0_d    = 1'b0;
                end else begin
                    slot_d = slot_q + CW'(1);
                end
            end

            S_LOW: begin
                if (slot_last) begin
                    slot_d = '0;
                    if (bit_cnt_q == 6'd32) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_HIGH;
                        out1_d  = sr_q[31];
                        out0_d  = ~sr_q[31];
                    end
                end else begin
                    slot_d = slot_q + CW'(1);
                end
            end

            S_GAP: begin
                if (slot_last) begin
                    slot_d = '0;
                    if (gap_q == GW'(GAPSLOTS - 1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end else begin
                    slot_d = slot_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                out1_d  = 1'b0;
                out0_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset nulls the line at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            m_q       <= '0;
            bit_cnt_q <= '0;
            gap_q     <= '0;
            sr_q      <= '0;
            out1_q    <= 1'b0;
            out0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make all flops see pre-edge values.
            state_q   <= state_d;
            slot_q    <= slot_d;
            m_q       <= m_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            sr_q      <= sr_d;
            out1_q    <= out1_d;
            out0_q    <= out0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.out1 = out1_q;
    assign bus.out0 = out0_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_ar_txd.sv
// tb_ar_txd: self-checking bench for ar_txd.
// It uses a reduced clock frequency so that slot lengths are short:
// 10, 20 and 80 clocks at 100k, 50k and 12.5k.
module tb_ar_txd;

    localparam int FCLK     = 1000000;
    localparam int GAP_BITS = 4;
`ifdef AR_TXD_PARITY_INJ_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0]  adr;
        logic [22:0] dat;
        logic [1:0]  spd;
        logic        inj;
        logic        acc;    // expect the start to be accepted
        logic        first;  // expected line bit of the first HIGH slot
        logic        par;    // expected line bit of the 32nd HIGH slot
        int          lat;    // expected clocks from start to done
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic par_inj_tb = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ar_txd_if bus_if ();

    ar_txd #(.Fclk(FCLK), .GAP_BITS(GAP_BITS)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef AR_TXD_PARITY_INJ_EN
        .par_inj (par_inj_tb),
`endif
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_of(input logic [1:0] s);
        case (s)
            2'd1:    return FCLK / 12500;
            2'd2:    return FCLK / 50000;
            2'd3:    return FCLK / 100000;
            default: return 0;
        endcase
    endfunction

    // Reference word: wb[i] is line bit i+1 in transmit order.
    function automatic logic [31:0] word_bits(input logic [7:0] adr,
                                              input logic [22:0] dat,
                                              input logic inj);
        logic [31:0] wb;
        for (int i = 0; i < 8; i++)  wb[i]     = adr[7-i];
        for (int k = 0; k < 23; k++) wb[8+k]   = dat[k];
        wb[31] = (($countones({adr, dat}) % 2) == 0) ? 1'b1 : 1'b0;
        wb[31] = wb[31] ^ (inj & INJ_ON);
        return wb;
    endfunction

    // Send one word (entered on a falling edge) and follow it until done.
    task automatic run_word(input vec_t v, input bit poke, input string nm);
        int m, g, t, lat, mism, excl, highs, ones, gap_cnt, limit, s;
        logic [31:0] wb, seen;
        logic [7:0]  dadr;
        logic [22:0] ddat;
        logic        e1, e0, eb, ed;
        bit          done_seen;

        bus_if.start  = 1'b1;
        bus_if.tx_adr = v.adr;
        bus_if.tx_dat = v.dat;
        bus_if.speed  = v.spd;
        par_inj_tb    = v.inj;
        @(negedge clk);
        bus_if.start = 1'b0;

        if (!v.acc) begin
            mism = 0;
            for (int i = 0; i < 40; i++) begin
                if (bus_if.busy || bus_if.out1 || bus_if.out0 || bus_if.done) mism++;
                @(negedge clk);
            end
            check({nm, " ignored"}, mism, 0);
            return;
        end

        m = m_of(v.spd);
        g = 2 * GAP_BITS * m;
        wb = word_bits(v.adr, v.dat, v.inj);
        limit = 64 * m + g + 10;
        t = 0; lat = 0; mism = 0; excl = 0; highs = 0; ones = 0; gap_cnt = 0;
        seen = '0; done_seen = 1'b0;

        while (!done_seen && t <= limit) begin
            if (t < 64 * m) begin
                s = t / m;
                e1 = (s % 2 == 0) ? wb[s/2] : 1'b0;
                e0 = (s % 2 == 0) ? ~wb[s/2] : 1'b0;
                eb = 1'b1; ed = 1'b0;
            end else if (t < 64 * m + g) begin
                e1 = 1'b0; e0 = 1'b0; eb = 1'b1; ed = 1'b0;
            end else begin
                e1 = 1'b0; e0 = 1'b0; eb = 1'b0; ed = 1'b1;
            end
            if ({bus_if.out1, bus_if.out0, bus_if.busy, bus_if.done} !== {e1, e0, eb, ed})
                mism++;
            if (bus_if.out1 && bus_if.out0) excl++;
            if (t < 64 * m && (t % m) == 0 && ((t / m) % 2) == 0) begin
                seen[t/m/2] = bus_if.out1;
                if (bus_if.out1 || bus_if.out0) highs++;
                if (bus_if.out1) ones++;
            end
            if (t >= 64 * m && bus_if.busy) gap_cnt++;
            if (poke && t == 5 * m) begin
                bus_if.start  = 1'b1;
                bus_if.tx_adr = ~v.adr;
                bus_if.tx_dat = ~v.dat;
            end
            if (poke && t == 5 * m + 1) bus_if.start = 1'b0;
            if (bus_if.done) begin
                done_seen = 1'b1;
                lat = t + 1;
            end else begin
                t++;
                @(negedge clk);
            end
        end

        for (int i = 0; i < 8; i++)  dadr[7-i] = seen[i];
        for (int k = 0; k < 23; k++) ddat[k]   = seen[8+k];

        check({nm, " done_seen"}, done_seen, 1);
        check({nm, " latency"}, lat, v.lat);
        check({nm, " waveform"}, mism, 0);
        check({nm, " exclusive"}, excl, 0);
        check({nm, " high_slots"}, highs, 32);
        check({nm, " gap"}, gap_cnt, g);
        check({nm, " first_bit"}, seen[0], v.first);
        check({nm, " parity_bit"}, seen[31], v.par);
        check({nm, " rx_adr"}, dadr, v.adr);
        check({nm, " rx_dat"}, ddat, v.dat);
        check({nm, " rx_ce_wr"}, ones % 2, (v.inj & INJ_ON) ? 0 : 1);
    endtask

    function automatic vec_t mk(input logic [7:0] adr, input logic [22:0] dat,
                                input logic [1:0] spd, input logic inj,
                                input logic acc, input logic first,
                                input logic par, input int lat);
        vec_t v;
        v.adr = adr; v.dat = dat; v.spd = spd; v.inj = inj;
        v.acc = acc; v.first = first; v.par = par; v.lat = lat;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        vec_t v;

        // Hand-derived: latency = 64*M + 8*M + 1 with M = 10, 20, 80.
        vecs.push_back(mk(8'hA5, 23'h000001, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 721));
        vecs.push_back(mk(8'h3C, 23'h000000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1441));
        vecs.push_back(mk(8'hA5, 23'h000001, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5761));
        vecs.push_back(mk(8'hFF, 23'h7FFFFF, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 721));
        vecs.push_back(mk(8'h00, 23'h000000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk(8'h80, 23'h400000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 721));
`ifdef AR_TXD_PARITY_INJ_EN
        vecs.push_back(mk(8'h01, 23'h000000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 721));
        vecs.push_back(mk(8'h01, 23'h000000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 721));
`endif

        bus_if.start = 1'b0; bus_if.tx_adr = '0; bus_if.tx_dat = '0; bus_if.speed = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out1", bus_if.out1, 0);
        check("reset_out0", bus_if.out0, 0);
        check("reset_busy", bus_if.busy, 0);
        check("reset_done", bus_if.done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors run back to back: each start lands in the done cycle.
        for (int i = 0; i < vecs.size(); i++)
            run_word(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Start pulses while busy must not disturb the word in flight.
        run_word(vecs[0], 1'b1, "busy_poke");

        // Reset in the HIGH slot of bit 10 of a 100k word.
        bus_if.start = 1'b1; bus_if.tx_adr = 8'h5A; bus_if.tx_dat = 23'h000002;
        bus_if.speed = 2'd3; par_inj_tb = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (18 * m_of(2'd3)) @(negedge clk);
        check("midword_bit10", bus_if.out1, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_out1", bus_if.out1, 0);
        check("rst_async_out0", bus_if.out0, 0);
        check("rst_async_busy", bus_if.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", bus_if.busy | bus_if.out1 | bus_if.out0, 0);
        run_word(vecs[1], 1'b0, "post_rst");

        // Random words at all rates against the reference model.
        for (int r = 0; r < 6; r++) begin
            v.adr = 8'($urandom);
            v.dat = 23'($urandom);
            v.spd = 2'($urandom_range(1, 3));
            v.inj = INJ_ON ? 1'($urandom_range(0, 1)) : 1'b0;
            v.acc = 1'b1;
            v.first = v.adr[7];
            v.par = word_bits(v.adr, v.dat, v.inj) >> 31;
            v.lat = 64 * m_of(v.spd) + 2 * GAP_BITS * m_of(v.spd) + 1;
            run_word(v, 1'b0, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
